// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle controller: states, opcodes and
// datapath select encodings.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALUSRCA_PC    = 2'b00;
   localparam logic [1:0] ALUSRCA_OLDPC = 2'b01;
   localparam logic [1:0] ALUSRCA_RS1   = 2'b10;

   localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
   localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
   localparam logic [1:0] ALUSRCB_FOUR = 2'b10;

   localparam logic [1:0] RESULTSRC_ALUOUT    = 2'b00;
   localparam logic [1:0] RESULTSRC_DATA      = 2'b01;
   localparam logic [1:0] RESULTSRC_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMMSRC_I = 2'b00;
   localparam logic [1:0] IMMSRC_S = 2'b01;
   localparam logic [1:0] IMMSRC_B = 2'b10;
   localparam logic [1:0] IMMSRC_J = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Opcode to immediate-format decoder; purely combinational so the pipelined
// core can reuse it in its decode stage.
module instr_dec
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] immsrc
);

   always_comb begin
      immsrc = IMMSRC_I;
      case (op)
         OP_SW:   immsrc = IMMSRC_S;
         OP_BEQ:  immsrc = IMMSRC_B;
         OP_JAL:  immsrc = IMMSRC_J;
         default: immsrc = IMMSRC_I;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects and write strobes.
//
// state      | meaning
// FETCH      | read instruction at PC, PC += 4 on mem_ready
// DECODE     | read registers, compute branch/jump target into ALUOut
// MEMADR     | compute load/store address rs1 + imm
// MEMREAD    | load data read, waits for mem_ready
// MEMWB      | write loaded data to rd
// MEMWRITE   | store write request held until mem_ready
// EXECUTER   | register-register ALU operation
// EXECUTEI   | register-immediate ALU operation
// ALUWB      | write ALUOut to rd
// JAL        | PC <= target, compute OldPC + 4 for the link
// BEQ        | compare rs1/rs2, take branch when zero
// ILLEGAL    | unknown opcode trap, left only by reset
module main_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] immsrc,
   output logic       regwrite,
   output logic       illegal_instr,
   output logic       instr_done
);

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;

   logic       pcupdate, branch;
   logic       adrsrc_c, memwrite_c, irwrite_c, regwrite_c, done_c;
   logic [1:0] resultsrc_c, alusrca_c, alusrcb_c, aluop_c;

   instr_dec u_instr_dec (
      .op     (op),
      .immsrc (immsrc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      pcupdate    = 1'b0;
      branch      = 1'b0;
      adrsrc_c    = 1'b0;
      memwrite_c  = 1'b0;
      irwrite_c   = 1'b0;
      regwrite_c  = 1'b0;
      done_c      = 1'b0;
      resultsrc_c = 2'b00;
      alusrca_c   = 2'b00;
      alusrcb_c   = 2'b00;
      aluop_c     = 2'b00;
      case (state_q)
         S_FETCH: begin
            alusrca_c   = ALUSRCA_PC;
            alusrcb_c   = ALUSRCB_FOUR;
            aluop_c     = ALUOP_ADD;
            resultsrc_c = RESULTSRC_ALURESULT;
            irwrite_c   = mem_ready;
            pcupdate    = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrca_c = ALUSRCA_OLDPC;
            alusrcb_c = ALUSRCB_IMM;
            aluop_c   = ALUOP_ADD;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default: begin
                  illegal_d = 1'b1;
                  if (ILLEGAL_HALT) begin
                     state_d = S_ILLEGAL;
                  end else begin
                     state_d = S_FETCH;
                     done_c  = 1'b1;
                  end
               end
            endcase
         end
         S_MEMADR: begin
            alusrca_c = ALUSRCA_RS1;
            alusrcb_c = ALUSRCB_IMM;
            aluop_c   = ALUOP_ADD;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adrsrc_c    = 1'b1;
            resultsrc_c = RESULTSRC_ALUOUT;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc_c = RESULTSRC_DATA;
            regwrite_c  = 1'b1;
            done_c      = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWRITE: begin
            adrsrc_c    = 1'b1;
            resultsrc_c = RESULTSRC_ALUOUT;
            memwrite_c  = 1'b1;
            if (mem_ready) begin
               done_c  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECUTER: begin
            alusrca_c = ALUSRCA_RS1;
            alusrcb_c = ALUSRCB_RS2;
            aluop_c   = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            alusrca_c = ALUSRCA_RS1;
            alusrcb_c = ALUSRCB_IMM;
            aluop_c   = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            resultsrc_c = RESULTSRC_ALUOUT;
            regwrite_c  = 1'b1;
            done_c      = 1'b1;
            state_d     = S_FETCH;
         end
         S_JAL: begin
            alusrca_c   = ALUSRCA_OLDPC;
            alusrcb_c   = ALUSRCB_FOUR;
            aluop_c     = ALUOP_ADD;
            resultsrc_c = RESULTSRC_ALUOUT;
            pcupdate    = 1'b1;
            state_d     = S_ALUWB;
         end
         S_BEQ: begin
            alusrca_c   = ALUSRCA_RS1;
            alusrcb_c   = ALUSRCB_RS2;
            aluop_c     = ALUOP_SUB;
            resultsrc_c = RESULTSRC_ALUOUT;
            branch      = 1'b1;
            done_c      = 1'b1;
            state_d     = S_FETCH;
         end
         S_ILLEGAL: begin
            state_d = S_ILLEGAL;
         end
         default: begin
            // unused encodings look like FETCH but never strobe
            alusrca_c   = ALUSRCA_PC;
            alusrcb_c   = ALUSRCB_FOUR;
            aluop_c     = ALUOP_ADD;
            resultsrc_c = RESULTSRC_ALURESULT;
            state_d     = S_FETCH;
         end
      endcase
   end

   // Reset must silence strobes immediately, not one edge later.
   assign pcwrite       = ~reset & (pcupdate | (branch & zero));
   assign irwrite       = ~reset & irwrite_c;
   assign memwrite      = ~reset & memwrite_c;
   assign regwrite      = ~reset & regwrite_c;
   assign instr_done    = ~reset & done_c;
   assign adrsrc        = ~reset & adrsrc_c;
   assign resultsrc     = reset ? RESULTSRC_ALURESULT : resultsrc_c;
   assign alusrca       = reset ? ALUSRCA_PC : alusrca_c;
   assign alusrcb       = reset ? ALUSRCB_FOUR : alusrcb_c;
   assign aluop         = reset ? ALUOP_ADD : aluop_c;
   assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized bench for main_fsm: two instances (halting and NOP illegal handling)
// checked each cycle against an instruction-plan reference model.
module tb_main_fsm;

   typedef enum {P_FETCH, P_DECODE, P_ADDR, P_READ, P_LOADWB, P_WRITE,
                 P_ALU_R, P_ALU_I, P_ALUWB, P_JAL, P_BEQ, P_HALT} ph_e;

   localparam int NCYC = 3000;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s [2];
   logic [6:0] op_s  [2];
   logic       zero_s[2];
   logic       mr_s  [2];

   logic       pcw[2], adr[2], mw[2], irw[2], rw[2], ill[2], dn[2];
   logic [1:0] res[2], asa[2], asb[2], aop[2], imm[2];
   logic [16:0] got[2];

   for (genvar g = 0; g < 2; g++) begin : g_inst
      main_fsm #(.ILLEGAL_HALT(g == 0)) u_dut (
         .clk           (clk),
         .reset         (rst_s[g]),
         .op            (op_s[g]),
         .zero          (zero_s[g]),
         .mem_ready     (mr_s[g]),
         .pcwrite       (pcw[g]),
         .adrsrc        (adr[g]),
         .memwrite      (mw[g]),
         .irwrite       (irw[g]),
         .resultsrc     (res[g]),
         .alusrca       (asa[g]),
         .alusrcb       (asb[g]),
         .aluop         (aop[g]),
         .immsrc        (imm[g]),
         .regwrite      (rw[g]),
         .illegal_instr (ill[g]),
         .instr_done    (dn[g])
      );
      assign got[g] = {pcw[g], adr[g], mw[g], irw[g], res[g], asa[g], asb[g],
                       aop[g], imm[g], rw[g], ill[g], dn[g]};
   end

   int  n_cmp = 0;
   int  n_err = 0;

   ph_e cur[2];
   ph_e plan[2][$];
   bit  flag[2];
   int  halt_cnt[2];

   task automatic check_eq(input string tag, input logic [16:0] obs, input logic [16:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                        7'b1101111, 7'b1100011};
   endfunction

   // Output vector layout: pcwrite,adrsrc,memwrite,irwrite,resultsrc,alusrca,
   // alusrcb,aluop,immsrc,regwrite,illegal_instr,instr_done
   function automatic logic [16:0] expect_out(input ph_e p, input logic [6:0] op,
                                               input logic z, input logic mr,
                                               input logic rst, input bit fl,
                                               input bit halt);
      logic pc = 0, ad = 0, mwr = 0, ir = 0, rwr = 0, il, d = 0;
      logic [1:0] r = 0, a = 0, b = 0, al = 0, im;
      im = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
           (op == 7'b1101111) ? 2'd3 : 2'd0;
      il = fl;
      if (rst) begin
         r = 2; b = 2; il = 0;
      end else begin
         case (p)
            P_FETCH:  begin r = 2; b = 2; ir = mr; pc = mr; end
            P_DECODE: begin a = 1; b = 1; d = !is_legal(op) && !halt; end
            P_ADDR:   begin a = 2; b = 1; end
            P_READ:   begin ad = 1; end
            P_LOADWB: begin r = 1; rwr = 1; d = 1; end
            P_WRITE:  begin ad = 1; mwr = 1; d = mr; end
            P_ALU_R:  begin a = 2; b = 0; al = 2; end
            P_ALU_I:  begin a = 2; b = 1; al = 2; end
            P_ALUWB:  begin rwr = 1; d = 1; end
            P_JAL:    begin a = 1; b = 2; pc = 1; end
            P_BEQ:    begin a = 2; al = 1; pc = z; d = 1; end
            default:  begin end
         endcase
      end
      return {pc, ad, mwr, ir, r, a, b, al, im, rwr, il, d};
   endfunction

   task automatic next_phase(input int k);
      if (plan[k].size() > 0) cur[k] = plan[k].pop_front();
      else                    cur[k] = P_FETCH;
   endtask

   task automatic advance(input int k);
      if (rst_s[k]) begin
         cur[k] = P_FETCH;
         plan[k].delete();
         flag[k] = 0;
         return;
      end
      case (cur[k])
         P_FETCH: if (mr_s[k]) cur[k] = P_DECODE;
         P_DECODE: begin
            case (op_s[k])
               7'b0000011: plan[k] = '{P_ADDR, P_READ, P_LOADWB};
               7'b0100011: plan[k] = '{P_ADDR, P_WRITE};
               7'b0110011: plan[k] = '{P_ALU_R, P_ALUWB};
               7'b0010011: plan[k] = '{P_ALU_I, P_ALUWB};
               7'b1101111: plan[k] = '{P_JAL, P_ALUWB};
               7'b1100011: plan[k] = '{P_BEQ};
               default: begin
                  flag[k] = 1;
                  if (k == 0) plan[k] = '{P_HALT};
                  else        plan[k].delete();
               end
            endcase
            next_phase(k);
         end
         P_READ, P_WRITE: if (mr_s[k]) next_phase(k);
         P_HALT: cur[k] = P_HALT;
         default: next_phase(k);
      endcase
   endtask

   function automatic logic [6:0] pick_op();
      logic [6:0] o;
      case ($urandom_range(0, 13))
         0, 1:    o = 7'b0000011;
         2, 3:    o = 7'b0100011;
         4, 5:    o = 7'b0110011;
         6, 7:    o = 7'b0010011;
         8, 9:    o = 7'b1101111;
         10, 11:  o = 7'b1100011;
         12:      o = 7'b1111111;
         default: o = 7'($urandom_range(0, 127));
      endcase
      return o;
   endfunction

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_s[k] = 1; op_s[k] = 7'b0000011; zero_s[k] = 0; mr_s[k] = 0;
         cur[k] = P_FETCH; flag[k] = 0; halt_cnt[k] = 0;
      end
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (c < 3)
               rst_s[k] = 1;
            else
               rst_s[k] = (halt_cnt[k] > 24) || ($urandom_range(0, 79) == 0);
            mr_s[k]   = ($urandom_range(0, 3) != 0);
            zero_s[k] = 1'($urandom_range(0, 1));
            if (cur[k] == P_FETCH) op_s[k] = pick_op();
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("c%0d_u%0d_%s%s", c, k, cur[k].name(), rst_s[k] ? "_rst" : ""),
                     got[k],
                     expect_out(cur[k], op_s[k], zero_s[k], mr_s[k], rst_s[k], flag[k], k == 0));
            advance(k);
            halt_cnt[k] = (cur[k] == P_HALT) ? halt_cnt[k] + 1 : 0;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
Multicycle control state machine for the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath mux selects and write strobes.
- Produces aluop, which feeds the ALU decoder downstream.
- Memory accesses use a ready handshake, so variable-latency memory stalls the machine cleanly.

Parameters:
- ILLEGAL_HALT, 1: 1 = an unknown opcode enters ILLEGAL and halts until reset; 0 = it is treated as a NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = result
- memwrite  out  1  memory write request
- irwrite  out  1  IR and OldPC enable
- resultsrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alusrca  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- alusrcb  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- aluop  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- immsrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- regwrite  out  1  register file write enable
- illegal_instr  out  1  sticky illegal-opcode flag
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- The 4-bit state register is clocked on clk. Reset asynchronously forces state FETCH and clears illegal_instr.
- While reset is high, pcwrite, irwrite, memwrite, regwrite and instr_done are forced 0. All other outputs take their FETCH values: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
- Outputs are Moore decodes of state, with three exceptions:
  - pcwrite = pcupdate | (branch & zero).
  - irwrite and FETCH's pcupdate are gated by mem_ready.
  - immsrc is decoded from op combinationally: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- Every select and strobe not listed for a state is 0.
- States, their outputs, and next state:
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, irwrite=mem_ready, pcupdate=mem_ready. Stay while !mem_ready; otherwise go to DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=00. Branches on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - otherwise -> ILLEGAL (ILLEGAL_HALT=1) or FETCH with instr_done=1 (ILLEGAL_HALT=0)
  - MEMADR: alusrca=10, alusrcb=01, aluop=00. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
  - MEMREAD: adrsrc=1, resultsrc=00. Hold until mem_ready, then go to MEMWB.
  - MEMWB: resultsrc=01, regwrite=1, instr_done=1 -> FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 held for every cycle until mem_ready. On the mem_ready cycle: instr_done=1, then FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10 -> ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10 -> ALUWB.
  - ALUWB: resultsrc=00, regwrite=1, instr_done=1 -> FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1 -> ALUWB.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, instr_done=1 -> FETCH.
  - ILLEGAL: all strobes 0, illegal_instr=1. Self-loop; exit only by reset.
- Instruction latencies with mem_ready always 1:
  - lw = 5 cycles
  - sw, R-type, I-type, jal = 4 cycles
  - beq = 3 cycles
- Each stall cycle (mem_ready=0) adds exactly one cycle. No strobe repeats during a stall, except memwrite, which is a level request.
- Reset asserted mid-instruction (including during a stall) aborts immediately. The cycle after reset deasserts is FETCH.
- Unused state encodings decode to FETCH outputs with strobes 0 and next state FETCH.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
  - select encodings: ALUSRCA_*, ALUSRCB_*, RESULTSRC_*, ALUOP_*, IMMSRC_*
- One sub-module is natural: instr_dec, the combinational op -> immsrc decoder, shared later with the pipelined core.

Test Plan:
- Reset mid-MEMREAD with mem_ready=0 -> state FETCH, all strobes 0 during reset; first post-reset cycle has irwrite=mem_ready.
- op=0000011 (lw), mem_ready=1 -> path FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 and resultsrc=01 only in cycle 5; instr_done in cycle 5.
- op=0100011 (sw) with mem_ready low for 3 cycles in MEMWRITE -> memwrite=1 for 4 consecutive cycles, adrsrc=1, regwrite never set, instr_done on the 4th.
- op=1100011 (beq), zero=1 -> pcwrite=1 in BEQ, aluop=01; repeat with zero=0 -> pcwrite=0, 3-cycle instruction.
- op=1101111 (jal) -> pcwrite=1 in FETCH and JAL, alusrca=01/alusrcb=10 in JAL, regwrite in ALUWB, immsrc=11.
- op=1111111, ILLEGAL_HALT=1 -> ILLEGAL after DECODE, illegal_instr=1, no strobes for 20 cycles; ILLEGAL_HALT=0 -> back to FETCH, instr_done=1.
